byte_serial_sub32: RTL



---
 rtl/byte_serial_sub32.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/byte_serial_sub32.sv
// byte_serial_sub32: multi-cycle subtractor/comparator.
// Computes A - B as A + ~B + 1, one SLICE-bit slice per clock.
// The carry between slices is held in a register.
// Produces a registered difference plus zero, unsigned-less-than and
// signed-less-than flags, with valid/ready handshakes on both sides.
module byte_serial_sub32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             zero_o,
    output logic             ltu_o,
    output logic             lt_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ltu_q, ltu_d;
    logic             lt_q, lt_d;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE:0]   slice_sum;

    // Pick the operand slices addressed by the counter, then form the
    // narrow slice sum a + ~b + carry (bit SLICE is the carry out).
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_slice = a_q[i*SLICE +: SLICE];
                b_slice = b_q[i*SLICE +: SLICE];
            end
        end
        slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE{1'b0}}, carry_q};
    end

    // Next-state, datapath update and flag computation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ltu_d   = ltu_q;
        lt_d    = lt_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        diff_d[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
                    end
                end
                carry_d = slice_sum[SLICE];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_SLICE) begin
                    // Flags use the difference including the slice written
                    // this cycle, so they are taken from diff_d, not diff_q.
                    cnt_d   = '0;
                    state_d = DONE;
                    zero_d  = (diff_d == '0);
                    ltu_d   = ~slice_sum[SLICE];
                    lt_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? a_q[WIDTH-1]
                                                             : diff_d[WIDTH-1];
                end
            end

            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            zero_q  <= 1'b0;
            ltu_q   <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ltu_q   <= ltu_d;
            lt_q    <= lt_d;
        end
    end

    // Handshake outputs decode from state only.
    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
        diff_o  = diff_q;
        zero_o  = zero_q;
        ltu_o   = ltu_q;
        lt_o    = lt_q;
    end

endmodule
